// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, op-code width and the op-code encodings.
// Used by the alu itself and by every block that drives it.
package alu_pkg;

  localparam int XLEN  = 32;
  localparam int CTRLW = 4;

  typedef logic [XLEN-1:0]  word_t;
  typedef logic [CTRLW-1:0] ctrl_t;

  localparam ctrl_t OP_ADD  = 4'b0000;
  localparam ctrl_t OP_SUB  = 4'b1000;
  localparam ctrl_t OP_SLT  = 4'b0010;
  localparam ctrl_t OP_SLTU = 4'b0011;
  localparam ctrl_t OP_AND  = 4'b0111;
  localparam ctrl_t OP_OR   = 4'b0110;
  localparam ctrl_t OP_XOR  = 4'b0100;
  localparam ctrl_t OP_SLL  = 4'b0001;
  localparam ctrl_t OP_SRL  = 4'b0101;
  localparam ctrl_t OP_SRA  = 4'b1101;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational integer ALU.
// Undefined op codes produce zero.
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [CTRLW-1:0] ctrl_i,
  output logic [XLEN-1:0]  result_o
);

  logic [4:0] shamt;

  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (ctrl_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      OP_SLTU: result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SLL:  result_o = a_i << shamt;
      OP_SRL:  result_o = a_i >> shamt;
      OP_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from the slot after
// last_grant_i and grants the first eligible requester.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] eligible_i,
  input  logic [IDW-1:0]  last_grant_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_idx_o
);

  int           cand;
  logic [IDW-1:0] idx;
  logic         found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    idx         = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(last_grant_i) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      idx = IDW'(cand);
      if (!found && eligible_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ valid/ready requesters with
// round-robin arbitration and a one-deep registered response slot per requester.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*XLEN-1:0]  req_a_i,
  input  logic [NREQ*XLEN-1:0]  req_b_i,
  input  logic [NREQ*CTRLW-1:0] req_ctrl_i,
  output logic [NREQ-1:0]       rsp_valid_o,
  input  logic [NREQ-1:0]       rsp_ready_i,
  output logic [NREQ*XLEN-1:0]  rsp_data_o,
  output logic                  busy_o
);

  logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [NREQ*XLEN-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]       last_grant_q, last_grant_d;

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic [XLEN-1:0]  alu_a, alu_b, alu_y;
  logic [CTRLW-1:0] alu_ctrl;

  // A slot that is draining this cycle can accept a refill with no bubble.
  assign eligible = req_valid_i & (~rsp_valid_q | rsp_ready_i);

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .eligible_i   (eligible),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx)
  );

  assign req_ready_o = rst_i ? '0 : grant;

  always_comb begin
    alu_a    = req_a_i[int'(grant_idx)*XLEN +: XLEN];
    alu_b    = req_b_i[int'(grant_idx)*XLEN +: XLEN];
    alu_ctrl = req_ctrl_i[int'(grant_idx)*CTRLW +: CTRLW];
  end

  alu u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .ctrl_i   (alu_ctrl),
    .result_o (alu_y)
  );

  always_comb begin
    rsp_valid_d  = rsp_valid_q & ~rsp_ready_i;
    rsp_data_d   = rsp_data_q;
    last_grant_d = last_grant_q;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid_i[k] && grant[k]) begin
        rsp_valid_d[k]                = 1'b1;
        rsp_data_d[k*XLEN +: XLEN]    = alu_y;
        last_grant_d                  = IDW'(k);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      last_grant_q <= IDW'(NREQ-1);
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = |rsp_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: per-requester op queues drive a 2-requester instance against a
// round-robin reference and a result scoreboard; a 3-requester instance checks grant order.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N = 2;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] exp;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*32-1:0] req_a, req_b, rsp_data;
  logic [N*4-1:0] req_ctrl;
  logic           busy;

  logic [2:0]  v3, rdy3, rv3, rr3;
  logic [95:0] a3, b3, rd3;
  logic [11:0] c3;
  logic        busy3;

  alu_arbiter #(.NREQ(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_ctrl_i(req_ctrl),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .busy_o(busy)
  );

  alu_arbiter #(.NREQ(3)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(v3), .req_ready_o(rdy3),
    .req_a_i(a3), .req_b_i(b3), .req_ctrl_i(c3),
    .rsp_valid_o(rv3), .rsp_ready_i(rr3),
    .rsp_data_o(rd3), .busy_o(busy3)
  );

  int vec_count  = 0;
  int miss_count = 0;

  op_t         pend [N][$];
  logic [31:0] sb   [N][$];
  int          m_last;
  logic [N-1:0] rsp_rdy;

  logic [N-1:0]    s_ready, s_valid;
  logic [N*32-1:0] s_data;

  op_t      vecs [15];
  logic [2:0] exp3 [10];
  int       glog [$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive from the op queues, check at the falling edge, advance the reference.
  task automatic applyStimulus();
    logic [N-1:0] exp_grant, exp_valid;
    int c;
    for (int k = 0; k < N; k++) begin
      if (pend[k].size() > 0) begin
        req_valid[k]          = 1'b1;
        req_a[k*32 +: 32]     = pend[k][0].a;
        req_b[k*32 +: 32]     = pend[k][0].b;
        req_ctrl[k*4 +: 4]    = pend[k][0].ctrl;
      end else begin
        req_valid[k]          = 1'b0;
        req_a[k*32 +: 32]     = '0;
        req_b[k*32 +: 32]     = '0;
        req_ctrl[k*4 +: 4]    = '0;
      end
    end
    rsp_ready = rsp_rdy;
    @(negedge clk);
    exp_grant = '0;
    if (!rst) begin
      for (int i = 1; i <= N; i++) begin
        c = (m_last + i) % N;
        if (exp_grant == '0 && req_valid[c] && (sb[c].size() == 0 || rsp_rdy[c]))
          exp_grant[c] = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) exp_valid[k] = (sb[k].size() != 0);
    checkOutput("req_ready", 64'(req_ready), 64'(exp_grant));
    checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
    checkOutput("busy", 64'(busy), 64'(|exp_valid));
    for (int k = 0; k < N; k++)
      if (sb[k].size() > 0)
        checkOutput($sformatf("rsp_data[%0d]", k), 64'(rsp_data[k*32 +: 32]), 64'(sb[k][0]));
    s_ready = req_ready;
    s_valid = rsp_valid;
    s_data  = rsp_data;
    if (rst) begin
      for (int k = 0; k < N; k++) sb[k].delete();
      m_last = N - 1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (sb[k].size() > 0 && rsp_rdy[k]) void'(sb[k].pop_front());
        if (exp_grant[k]) begin
          sb[k].push_back(pend[k][0].exp);
          m_last = k;
        end
      end
    end
    for (int k = 0; k < N; k++)
      if (req_valid[k] && req_ready[k] && pend[k].size() > 0) void'(pend[k].pop_front());
    @(posedge clk);
    #1;
  endtask

  function automatic bit work_left();
    for (int k = 0; k < N; k++)
      if (pend[k].size() > 0 || sb[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_idle(input int max_cycles);
    int n = 0;
    while (work_left() && n < max_cycles) begin
      applyStimulus();
      n++;
    end
    if (work_left()) begin
      vec_count++;
      miss_count++;
      $display("[TB] FAIL idle_timeout: work still pending after %0d cycles, required none", n);
      for (int k = 0; k < N; k++) begin
        pend[k].delete();
        sb[k].delete();
      end
    end
  endtask

  // Requesters must hold valid and operands steady until accepted.
  logic [N-1:0]    hold_q = '0;
  logic [N*32-1:0] a_q, b_q;
  logic [N*4-1:0]  c_q;
  always @(negedge clk) begin
    for (int k = 0; k < N; k++)
      if (hold_q[k])
        assert (req_valid[k] && req_a[k*32 +: 32] == a_q[k*32 +: 32] &&
                req_b[k*32 +: 32] == b_q[k*32 +: 32] && req_ctrl[k*4 +: 4] == c_q[k*4 +: 4])
        else $error("[TB] requester %0d changed its request before acceptance", k);
    hold_q <= req_valid & ~req_ready;
    a_q    <= req_a;
    b_q    <= req_b;
    c_q    <= req_ctrl;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{32'd5,        32'd3,        OP_ADD,  32'd8};
    vecs[1]  = '{32'd10,       32'd4,        OP_SUB,  32'd6};
    vecs[2]  = '{32'd0,        32'd1,        OP_SUB,  32'hFFFFFFFF};
    vecs[3]  = '{32'hFFFFFFFF, 32'd1,        OP_ADD,  32'd0};
    vecs[4]  = '{32'hFFFFFFFF, 32'd1,        OP_SLT,  32'd1};
    vecs[5]  = '{32'hFFFFFFFF, 32'd1,        OP_SLTU, 32'd0};
    vecs[6]  = '{32'd1,        32'hFFFFFFFF, OP_SLT,  32'd0};
    vecs[7]  = '{32'hF0F0F0F0, 32'hFF00FF00, OP_AND,  32'hF000F000};
    vecs[8]  = '{32'hF0F0F0F0, 32'h0F0F0000, OP_OR,   32'hFFFFF0F0};
    vecs[9]  = '{32'hFFFF0000, 32'hFF00FF00, OP_XOR,  32'h00FFFF00};
    vecs[10] = '{32'h80000000, 32'h00000024, OP_SRA,  32'hF8000000};
    vecs[11] = '{32'h80000000, 32'h00000024, OP_SRL,  32'h08000000};
    vecs[12] = '{32'd1,        32'd31,       OP_SLL,  32'h80000000};
    vecs[13] = '{32'd3,        32'h00000020, OP_SLL,  32'd3};
    vecs[14] = '{32'd5,        32'd3,        4'b1111, 32'd0};

    exp3[0] = 3'b001; exp3[1] = 3'b010; exp3[2] = 3'b100;
    exp3[3] = 3'b001; exp3[4] = 3'b010; exp3[5] = 3'b100;
    exp3[6] = 3'b001; exp3[7] = 3'b100; exp3[8] = 3'b001; exp3[9] = 3'b100;

    rst = 1'b1;
    rsp_rdy = '1;
    req_valid = '0; req_a = '0; req_b = '0; req_ctrl = '0; rsp_ready = '1;
    v3 = '0; rr3 = 3'b111;
    a3 = {32'd12, 32'd11, 32'd10};
    b3 = {3{32'd1}};
    c3 = {3{OP_ADD}};
    m_last = N - 1;

    $display("[TB] reset");
    applyStimulus();
    applyStimulus();
    checkOutput("reset_data", 64'(s_data), 64'd0);
    rst = 1'b0;

    $display("[TB] single ADD on requester 0");
    pend[0].push_back('{32'd5, 32'd3, OP_ADD, 32'd8});
    applyStimulus();
    checkOutput("t1_grant", 64'(s_ready), 64'b01);
    applyStimulus();
    checkOutput("t1_valid", 64'(s_valid), 64'b01);
    checkOutput("t1_data", 64'(s_data[31:0]), 64'd8);
    applyStimulus();
    checkOutput("t1_clear", 64'(s_valid), 64'b00);

    $display("[TB] vector table");
    for (int i = 0; i < 15; i++) pend[i % N].push_back(vecs[i]);
    run_idle(100);

    $display("[TB] contention");
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      pend[0].push_back('{32'd10, 32'd4, OP_SUB, 32'd6});
      pend[1].push_back('{32'hFFFFFFFF, 32'd1, OP_SLT, 32'd1});
    end
    for (int n = 0; n < 20 && work_left(); n++) begin
      applyStimulus();
      for (int k = 0; k < N; k++) if (s_ready[k]) glog.push_back(k);
    end
    checkOutput("t2_grant_count", 64'(glog.size()), 64'd8);
    for (int i = 1; i < glog.size(); i++)
      checkOutput($sformatf("t2_alternate%0d", i), 64'(glog[i] != glog[i-1]), 64'd1);
    run_idle(20);

    $display("[TB] backpressure");
    rsp_rdy = 2'b10;
    pend[0].push_back('{32'd1, 32'd2, OP_ADD, 32'd3});
    applyStimulus();
    checkOutput("t3_first_grant", 64'(s_ready), 64'b01);
    pend[0].push_back('{32'd7, 32'd7, OP_ADD, 32'd14});
    pend[1].push_back('{32'h000000FF, 32'h0000000F, OP_XOR, 32'h000000F0});
    applyStimulus();
    checkOutput("t3_blocked_grant", 64'(s_ready), 64'b10);
    checkOutput("t3_held_valid", 64'(s_valid[0]), 64'd1);
    applyStimulus();
    checkOutput("t3_none_eligible", 64'(s_ready), 64'b00);
    rsp_rdy = 2'b11;
    applyStimulus();
    checkOutput("t3_refill_grant", 64'(s_ready), 64'b01);
    checkOutput("t3_old_data", 64'(s_data[31:0]), 64'd3);
    applyStimulus();
    checkOutput("t3_no_bubble", 64'(s_valid[0]), 64'd1);
    checkOutput("t3_new_data", 64'(s_data[31:0]), 64'd14);
    run_idle(20);

    $display("[TB] reset mid-operation");
    rsp_rdy = 2'b00;
    pend[0].push_back('{32'd2, 32'd2, OP_ADD, 32'd4});
    pend[1].push_back('{32'd9, 32'd3, OP_SUB, 32'd6});
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("t5_both_held", 64'(s_valid), 64'b11);
    pend[0].push_back('{32'd1, 32'd1, OP_ADD, 32'd2});
    pend[1].push_back('{32'd3, 32'd1, OP_SUB, 32'd2});
    rsp_rdy = 2'b11;
    rst = 1'b1;
    applyStimulus();
    checkOutput("t5_ready_in_reset", 64'(s_ready), 64'b00);
    rst = 1'b0;
    applyStimulus();
    checkOutput("t5_valid_cleared", 64'(s_valid), 64'b00);
    checkOutput("t5_data_cleared", 64'(s_data), 64'd0);
    checkOutput("t5_first_grant", 64'(s_ready), 64'b01);
    run_idle(20);

    $display("[TB] three requesters");
    for (int i = 0; i < 10; i++) begin
      v3 = (i < 6) ? 3'b111 : 3'b101;
      @(negedge clk);
      checkOutput($sformatf("nreq3_grant%0d", i), 64'(rdy3), 64'(exp3[i]));
      @(posedge clk);
      #1;
    end
    v3 = 3'b000;
    @(negedge clk);
    checkOutput("nreq3_valid", 64'(rv3), 64'b100);
    checkOutput("nreq3_data2", 64'(rd3[95:64]), 64'd13);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
